// File: rtl/mk14_uart_pkg.sv
// Shared UART definitions for the MK14 serial link (transmitter and receiver).
// Holds the transmit FSM state type and the baud divisor helper.
package mk14_uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   // Truncating divisor; no fractional baud correction anywhere on the link.
   function automatic int clks_per_bit(input int mhz, input int baud);
      return (mhz * 1_000_000) / baud;
   endfunction

endpackage

// File: rtl/mk14_uart_tx_if.sv
// Byte handshake and status bundle between a byte producer (CPU port or dumper)
// and the MK14 UART transmitter.
interface mk14_uart_tx_if #(
   parameter int COUNT_W = 5
);
   logic [7:0]         i_data;
   logic               i_valid;
   logic               o_ready;
   logic               sout;
   logic               tx_wait;
   logic               o_busy;
   logic [COUNT_W-1:0] o_count;

   modport master (
      output i_data,
      output i_valid,
      input  o_ready,
      input  sout,
      input  tx_wait,
      input  o_busy,
      input  o_count
   );

   modport slave (
      input  i_data,
      input  i_valid,
      output o_ready,
      output sout,
      output tx_wait,
      output o_busy,
      output o_count
   );
endinterface

// File: rtl/mk14_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// Writes into a full FIFO are dropped even when a read happens on the same edge.
module mk14_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_wr, do_rd;

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_wr    = wr_en && !full;
      do_rd    = rd_en && !empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/mk14_uart_tx.sv
// MK14 8N1 serial transmitter: byte FIFO feeding an LSB-first shifter with a
// registered, glitch-free sout and back-to-back frames without idle gaps.
module mk14_uart_tx
   import mk14_uart_pkg::*;
#(
   parameter int CLOCK_FREQ_MHZ = 50,
   parameter int BAUD_RATE      = 115200,
   parameter int FIFO_DEPTH     = 16
) (
   input logic           clk,
   input logic           rst_n,
   mk14_uart_tx_if.slave bus
);
   localparam int CPB    = clks_per_bit(CLOCK_FREQ_MHZ, BAUD_RATE);
   localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   tx_state_t         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              sout_q, sout_d;

   logic              pop;
   logic              baud_last;
   logic [7:0]        fifo_data;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   mk14_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bus.i_valid),
      .wr_data (bus.i_data),
      .rd_en   (pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign baud_last   = (baud_q == BAUD_W'(CPB - 1));
   assign bus.o_ready = !fifo_full;
   assign bus.tx_wait = fifo_full;
   assign bus.o_busy  = (state_q != IDLE) || !fifo_empty;
   assign bus.o_count = fifo_count;
   assign bus.sout    = sout_q;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               baud_d  = '0;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            // Chaining straight into START keeps queued frames contiguous.
            if (baud_last) begin
               baud_d = '0;
               bit_d  = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_data;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // sout trails the FSM by one flop so the line never sees a combinational glitch.
      case (state_q)
         START:   sout_d = 1'b0;
         DATA:    sout_d = shift_q[0];
         default: sout_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         sout_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         sout_q  <= sout_d;
      end
   end

endmodule

// File: tb/tb_mk14_uart_tx.sv
// Scoreboard bench for mk14_uart_tx: directed pushes queue expected bytes, and an
// independent line decoder pops and compares every frame seen on sout.
module tb_mk14_uart_tx;

   // 2 MHz / 115200 baud = 17.36, truncated to 17 clocks per bit (short frames, same logic).
   localparam int MHZ   = 2;
   localparam int BAUD  = 115200;
   localparam int CPB   = 17;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int         checks = 0;
   int         failures = 0;
   int         cycle = 0;
   int         maxCount = 0;
   bit         monActive = 1'b0;
   logic [7:0] expQ[$];
   int         startTimes[$];

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      if (int'(bus.o_count) > maxCount) maxCount = int'(bus.o_count);
   end

   mk14_uart_tx_if #(.COUNT_W(CW)) bus ();

   mk14_uart_tx #(
      .CLOCK_FREQ_MHZ (MHZ),
      .BAUD_RATE      (BAUD),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Drives one byte for exactly one rising edge; track=1 queues it for the scoreboard.
   task automatic applyStimulus(input logic [7:0] data, input bit track);
      bus.i_data  = data;
      bus.i_valid = 1'b1;
      if (track) expQ.push_back(data);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_data  = 'x;
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n;
      n = 0;
      while ((bus.o_busy || monActive || expQ.size() != 0) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("[TB] FAIL %s_drain: still busy after %0d cycles, expected idle", name, n);
      end
   endtask

   // Line decoder: samples mid-bit on negedges, aborts any frame cut by reset.
   initial begin : monitor
      logic [7:0] rx;
      int         tick;
      int         idx;
      rx   = '0;
      tick = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            monActive = 1'b0;
         end else if (!monActive) begin
            if (bus.sout === 1'b0) begin
               monActive = 1'b1;
               tick      = 0;
               rx        = '0;
               startTimes.push_back(cycle);
            end
         end else begin
            tick++;
            if (tick == CPB / 2) begin
               checkOutput("start_bit", bus.sout, 0);
            end else if (tick > CPB / 2 && (tick - CPB / 2) % CPB == 0) begin
               idx = (tick - CPB / 2) / CPB;
               if (idx <= 8) begin
                  rx[idx-1] = bus.sout;
               end else begin
                  checkOutput("stop_bit", bus.sout, 1);
                  monActive = 1'b0;
                  if (expQ.size() == 0) begin
                     checks++;
                     failures++;
                     $display("[TB] FAIL frame_data: got 0x%0h, expected no frame", rx);
                  end else begin
                     checkOutput("frame_data", rx, expQ.pop_front());
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      bus.i_valid = 1'b0;
      bus.i_data  = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_sout", bus.sout, 1);
      checkOutput("rst_ready", bus.o_ready, 1);
      checkOutput("rst_tx_wait", bus.tx_wait, 0);
      checkOutput("rst_busy", bus.o_busy, 0);
      checkOutput("rst_count", bus.o_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single byte 0xA5: pushed at edge N, start bit from N+2, idle by N+2+10*CPB
      $display("[TB] single byte");
      applyStimulus(8'hA5, 1'b1);
      checkOutput("single_n0_sout", bus.sout, 1);
      checkOutput("single_n0_count", bus.o_count, 1);
      checkOutput("single_n0_busy", bus.o_busy, 1);
      @(posedge clk);
      #1;
      checkOutput("single_n1_sout", bus.sout, 1);
      checkOutput("single_n1_count", bus.o_count, 0);
      @(posedge clk);
      #1;
      checkOutput("single_n2_sout", bus.sout, 0);
      repeat (10 * CPB - 2) @(posedge clk);
      #1;
      checkOutput("single_busy_last", bus.o_busy, 1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("single_busy_end", bus.o_busy, 0);
      checkOutput("single_sout_end", bus.sout, 1);
      waitIdle("single", 20 * CPB);

      // Back-to-back frames must be contiguous
      $display("[TB] back to back");
      startTimes.delete();
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      applyStimulus(8'h55, 1'b1);
      waitIdle("b2b", 40 * CPB);
      checkOutput("b2b_frames", startTimes.size(), 3);
      if (startTimes.size() == 3) begin
         checkOutput("b2b_gap1", startTimes[1] - startTimes[0], 10 * CPB);
         checkOutput("b2b_gap2", startTimes[2] - startTimes[1], 10 * CPB);
      end

      // Fill while a frame is in flight, then push on the STOP->START pop edge
      $display("[TB] full and push-on-pop");
      applyStimulus(8'hEE, 1'b1);
      @(posedge clk);
      #1;
      for (int i = 1; i <= 17; i++) begin
         checkOutput("full_ready_before", bus.o_ready, (i <= 16));
         applyStimulus(8'(i), (i <= 16));
         if (i == 16) begin
            checkOutput("full_tx_wait", bus.tx_wait, 1);
            checkOutput("full_ready", bus.o_ready, 0);
         end
      end
      checkOutput("full_count", bus.o_count, 16);
      begin
         int n;
         n = 0;
         bus.i_data  = 8'h77;
         bus.i_valid = 1'b1;
         while (bus.o_count == CW'(16) && n < 20 * CPB) begin
            @(posedge clk);
            #1;
            n++;
         end
         bus.i_valid = 1'b0;
         bus.i_data  = 'x;
         checkOutput("pushpop_count", bus.o_count, 15);
         checkOutput("pushpop_ready", bus.o_ready, 1);
      end
      waitIdle("full", 25 * 10 * CPB);

      // Pointer wrap: 40 bytes, valid only while ready
      $display("[TB] pointer wrap");
      maxCount = 0;
      for (int i = 0; i < 40; i++) begin
         int g;
         g = 0;
         while (!bus.o_ready && g < 20 * CPB) begin
            @(posedge clk);
            #1;
            g++;
         end
         if (g >= 20 * CPB) begin
            checks++;
            failures++;
            $display("[TB] FAIL wrap_ready_wait: ready stayed 0 for %0d cycles, expected 1", g);
         end
         applyStimulus(8'(i), 1'b1);
      end
      waitIdle("wrap", 50 * 10 * CPB);
      checkOutput("wrap_max_count", maxCount, 16);

      // Reset during DATA bit 3 of 0xC3 with 0x99 still queued
      $display("[TB] reset mid-frame");
      applyStimulus(8'hC3, 1'b0);
      applyStimulus(8'h99, 1'b0);
      repeat (4 * CPB + CPB / 2) @(posedge clk);
      #1;
      checkOutput("midrst_bit3", bus.sout, 0);
      checkOutput("midrst_count_before", bus.o_count, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_sout", bus.sout, 1);
      checkOutput("midrst_count", bus.o_count, 0);
      checkOutput("midrst_busy", bus.o_busy, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("postrst_sout", bus.sout, 1);
      checkOutput("postrst_busy", bus.o_busy, 0);
      applyStimulus(8'h3C, 1'b1);
      waitIdle("postrst", 20 * CPB);
      repeat (4 * CPB) @(posedge clk);
      #1;

      checkOutput("scoreboard_empty", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
